twos_serial: RTL and testbench

TWOS_SERIAL -- requirements
Module: twos_serial

---
 rtl/twos_serial.sv | 145 ++++++++++++++
 tb/tb_twos_serial.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/twos_serial.sv
// Digit-serial two's-complement pass/negate/abs/negabs unit, DIGIT bits per cycle, LSB first.
// Optional macro TWOS_SAT_EN saturates overflowing results to the most-positive value.
module twos_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             neg_q, neg_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  logic             last;
  int               base;
  logic [DIGIT-1:0] slice;
  logic [DIGIT:0]   sum;
  logic             neg_in;

  // Handshake: a transfer happens on an edge where valid && ready; valid never
  // depends on ready, and out_data/out_ovf are frozen for as long as out_valid holds.
  assign accept    = in_valid && in_ready;
  assign last      = (cnt_q == CW'(N - 1));
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE: begin
        if (accept)         state_d = BUSY;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    case (in_mode)
      2'b00:   neg_in = 1'b0;
      2'b01:   neg_in = 1'b1;
      2'b10:   neg_in = in_data[WIDTH-1];
      default: neg_in = ~in_data[WIDTH-1];
    endcase
  end

  always_comb begin
    opnd_d     = opnd_q;
    work_d     = work_q;
    neg_d      = neg_q;
    ovf_pend_d = ovf_pend_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    base       = int'(cnt_q) * DIGIT;
    slice      = opnd_q[base +: DIGIT];
    sum        = {1'b0, ~slice} + {{DIGIT{1'b0}}, carry_q};
    if (accept) begin
      opnd_d     = in_data;
      work_d     = '0;
      neg_d      = neg_in;
      ovf_pend_d = neg_in && (in_data == MIN_VAL);
      cnt_d      = '0;
      carry_d    = 1'b1;
    end else if (state_q == BUSY) begin
      // Final carry-out is dropped, so negating zero wraps cleanly back to zero.
      work_d[base +: DIGIT] = neg_q ? sum[DIGIT-1:0] : slice;
      carry_d = neg_q ? sum[DIGIT] : carry_q;
      cnt_d   = last ? '0 : cnt_q + CW'(1);
      if (last) begin
`ifdef TWOS_SAT_EN
        out_data_d = ovf_pend_q ? SAT_VAL : work_d;
`else
        out_data_d = work_d;
`endif
        out_ovf_d = ovf_pend_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_q     <= '0;
      work_q     <= '0;
      neg_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      opnd_q     <= opnd_d;
      work_q     <= work_d;
      neg_q      <= neg_d;
      ovf_pend_q <= ovf_pend_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_twos_serial.sv
// Directed bench for twos_serial: an 8-bit/1-bit-digit instance and a 16-bit/4-bit-digit instance.
module tb_twos_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_iv, a_ir, a_ov, a_or, a_oo;
  logic [7:0] a_id, a_od;
  logic [1:0] a_im, a_st;

  logic        b_iv, b_ir, b_ov, b_or, b_oo;
  logic [15:0] b_id, b_od;
  logic [1:0]  b_im, b_st;

  int checks = 0;
  int errors = 0;

  twos_serial #(.WIDTH(8), .DIGIT(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .in_mode(a_im), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .out_ovf(a_oo), .dbg_state(a_st)
  );

  twos_serial #(.WIDTH(16), .DIGIT(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .in_mode(b_im), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .out_ovf(b_oo), .dbg_state(b_st)
  );

`ifdef TWOS_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference for the 16-bit instance: {ovf, result}.
  function automatic logic [16:0] ref16(input logic [1:0] mode, input logic [15:0] x);
    logic neg;
    logic [15:0] r;
    logic ovf;
    case (mode)
      2'b00:   neg = 1'b0;
      2'b01:   neg = 1'b1;
      2'b10:   neg = x[15];
      default: neg = !x[15];
    endcase
    if (!neg) return {1'b0, x};
    ovf = (x == 16'h8000);
    r   = 16'(0 - x);
    if (ovf && SAT) r = 16'h7fff;
    return {ovf, r};
  endfunction

  function automatic logic sel_ov(input bit sel);
    return sel ? b_ov : a_ov;
  endfunction

  // Issue one operand (block must be idle), wait for its result and check it.
  task automatic run_op(input bit sel, input logic [1:0] mode, input logic [15:0] data,
                        input logic [15:0] exp_d, input logic exp_o, input int exp_lat,
                        input string tag);
    int lat;
    if (sel) begin b_iv = 1'b1; b_id = data; b_im = mode; end
    else     begin a_iv = 1'b1; a_id = data[7:0]; a_im = mode; end
    @(posedge clk); #1;
    a_iv = 1'b0; b_iv = 1'b0;
    a_id = 8'($urandom); a_im = 2'($urandom); b_id = 16'($urandom); b_im = 2'($urandom);
    lat = 0;
    while (!sel_ov(sel) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, sel ? b_od : {8'h00, a_od}, exp_d);
    check({tag, "_ovf"}, sel ? b_oo : a_oo, exp_o);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    bit seen;
    logic [15:0] x;
    logic [1:0] m;
    logic [16:0] r;

    rst = 1'b1;
    a_iv = 0; a_id = 0; a_im = 0; a_or = 1;
    b_iv = 0; b_id = 0; b_im = 0; b_or = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", a_ov, 0);
    check("rst_data", a_od, 0);
    check("rst_ovf", a_oo, 0);
    check("rst_state", a_st, 0);
    rst = 1'b0;
    #1;
    check("rst_ready_a", a_ir, 1);
    check("rst_ready_b", b_ir, 1);

    run_op(0, 2'b01, 16'h05, 16'hfb, 0, 8, "neg05");
    run_op(0, 2'b10, 16'h80, SAT ? 16'h7f : 16'h80, 1, 8, "abs80");
    run_op(0, 2'b11, 16'h80, 16'h80, 0, 8, "nabs80");
    run_op(0, 2'b11, 16'h7f, 16'h81, 0, 8, "nabs7f");
    run_op(0, 2'b00, 16'ha5, 16'ha5, 0, 8, "passa5");
    run_op(0, 2'b01, 16'h00, 16'h00, 0, 8, "neg00");
    run_op(0, 2'b10, 16'h85, 16'h7b, 0, 8, "abs85");
    run_op(0, 2'b01, 16'h80, SAT ? 16'h7f : 16'h80, 1, 8, "neg80");
    run_op(0, 2'b10, 16'h33, 16'h33, 0, 8, "abs33");

    // Backpressure, then drain and accept on the same edge
    a_or = 1'b0;
    a_iv = 1'b1; a_id = 8'h03; a_im = 2'b01;
    @(posedge clk); #1;
    a_iv = 1'b0;
    lat = 0;
    while (!a_ov && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bp_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", a_ov, 1);
      check("bp_data", a_od, 8'hfd);
      check("bp_ovf", a_oo, 0);
      check("bp_ready", a_ir, 0);
      @(posedge clk); #1;
    end
    a_iv = 1'b1; a_id = 8'h05; a_im = 2'b01; a_or = 1'b1;
    #1;
    check("b2b_ready", a_ir, 1);
    @(posedge clk); #1;
    a_iv = 1'b0;
    check("b2b_valid", a_ov, 0);
    check("b2b_state", a_st, 1);
    lat = 0;
    while (!a_ov && lat < 40) begin @(posedge clk); #1; lat++; end
    check("b2b_lat", lat, 8);
    check("b2b_data", a_od, 8'hfb);
    @(posedge clk); #1;

    // Reset at BUSY count 3
    a_iv = 1'b1; a_id = 8'h22; a_im = 2'b01;
    @(posedge clk); #1;
    a_iv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_state", a_st, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_valid", a_ov, 0);
    check("mid_ready", a_ir, 1);
    check("mid_idle", a_st, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (a_ov) seen = 1;
    end
    check("mid_noresult", seen, 0);
    run_op(0, 2'b01, 16'h22, 16'hde, 0, 8, "after_rst");

    // 16-bit, 4-bit digits
    run_op(1, 2'b01, 16'h0001, 16'hffff, 0, 4, "b_neg1");
    run_op(1, 2'b10, 16'h8000, SAT ? 16'h7fff : 16'h8000, 1, 4, "b_abs8000");
    run_op(1, 2'b01, 16'h1230, 16'hedd0, 0, 4, "b_neg1230");
    for (int i = 0; i < 16; i++) begin
      x = 16'($urandom_range(0, 65535));
      m = 2'($urandom_range(0, 3));
      r = ref16(m, x);
      run_op(1, m, x, r[15:0], r[16], 4, "b_sweep");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
